mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles in WAIT before a transaction is aborted with error; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-low.
REQ-004 i_Addr  input  16  instruction-port address.
REQ-005 i_Rd  input  1  instruction-port read request (read-only port).
REQ-006 i_DataOut  output  16  instruction read data; valid while i_Done=1.
REQ-007 i_Done  output  1  instruction transaction complete, one-cycle pulse.
REQ-008 i_Stall  output  1  instruction port must hold request.
REQ-009 i_err  output  1  instruction transaction error, qualified by i_Done.
REQ-010 d_Addr, d_DataIn  input  16 each  data-port address and write data.
REQ-011 d_Rd, d_Wr  input  1 each  data-port read/write requests.
REQ-012 d_DataOut  output  16; d_Done, d_Stall, d_err  output  1 each; same meaning as instruction port.
REQ-013 m_Addr, m_DataIn  output  16 each  address/write data to shared memory system.
REQ-014 m_Rd, m_Wr  output  1 each  request strobes to memory system.
REQ-015 m_DataOut  input  16; m_Done, m_err  input  1 each; memory system response.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; owner register (I or D) and last_grant register (I or D).
REQ-017 Requesters hold Rd/Wr and Addr/DataIn stable from assertion until the cycle after their Done; the block SHALL sample requests only in IDLE.
REQ-018 IDLE: single valid requester -> owner=that port, latch Addr/DataIn/op, go ISSUE; both requesting -> owner = port not equal to last_grant; none -> stay IDLE.
REQ-019 d_Rd and d_Wr both high in IDLE SHALL be illegal: not forwarded, go RESP with owner=D and error set; arbitration with I SHALL still treat D as requesting only if legal.
REQ-020 ISSUE: m_Rd or m_Wr SHALL be high for exactly this one cycle with m_Addr/m_DataIn from latched registers; next state WAIT; last_grant<=owner.
REQ-021 m_Addr/m_DataIn SHALL remain driven from latched registers through ISSUE and WAIT; m_Rd=m_Wr=0 in all other states.
REQ-022 WAIT: m_Done=1 -> latch m_DataOut, error<=m_err, go RESP; m_err=1 without m_Done -> error<=1, go RESP; else increment timeout counter.
REQ-023 Timeout counter (8 bits) SHALL clear on entry to WAIT; when it reaches TIMEOUT-1 without m_Done -> error<=1, go RESP.
REQ-024 RESP: owner's Done=1, owner's err=error, owner's DataOut=latched data for this one cycle; next state IDLE unconditionally.
REQ-025 Non-owner Done/err SHALL be 0; DataOut outputs SHALL hold last latched value (no glitch to 0 required).
REQ-026 Stall per port SHALL be combinational: port request asserted AND NOT (state==RESP AND owner==that port).
REQ-027 Latency: uncontended request seen in IDLE at cycle 0 -> m_Rd/m_Wr at cycle 1 -> m_Done at cycle k -> port Done at cycle k+1.
REQ-028 Writes: Done with err=0 SHALL mean the write completed; DataOut content on write completion is don't-care.
REQ-029 m_Done arriving in IDLE, ISSUE or RESP SHALL be ignored.

Reset
REQ-030 rst low SHALL immediately force state=IDLE, last_grant=I, owner=I, counter=0, error=0, latched data/address=0.
REQ-031 During reset all outputs SHALL be 0 (m_Rd, m_Wr, Done, err, DataOut, m_Addr, m_DataIn); Stall follows REQ-026 and only stall outputs may be nonzero.
REQ-032 Reset asserted mid-transaction SHALL abort it with no Done pulse to either port; deassertion returns to IDLE operation next edge.

Verification
REQ-033 Single I read: i_Rd=1, i_Addr=0x1234, memory returns 0xBEEF with m_Done 4 cycles after m_Rd -> m_Rd one cycle with m_Addr=0x1234, i_Done pulse with i_DataOut=0xBEEF, i_err=0, total 6 cycles.
REQ-034 Simultaneous I and D requests after reset -> D granted first (last_grant=I), then I; repeat both held -> grants alternate D,I,D,I.
REQ-035 D write d_Addr=0x00A0, d_DataIn=0x5A5A -> m_Wr one cycle with those values, d_Done pulse, i_Stall stays 1 throughout if i_Rd held.
REQ-036 Memory never returns m_Done, TIMEOUT=64 -> owner Done with err=1 exactly 64 cycles after entering WAIT; next request serviced normally.
REQ-037 d_Rd=d_Wr=1 -> no m_Rd/m_Wr, d_Done and d_err pulse together one cycle later; m_err=1 with m_Done -> owner err=1.
REQ-038 rst asserted in WAIT -> outputs zero asynchronously, no Done pulse; late m_Done after release ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates instruction (read-only) and data ports onto one memory port; alternates grants under contention.
// Latency: request in IDLE -> strobe next cycle -> port Done one cycle after m_Done; requesters stall until their Done.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_Addr,
  input  logic        i_Rd,
  output logic [15:0] i_DataOut,
  output logic        i_Done,
  output logic        i_Stall,
  output logic        i_err,
  input  logic [15:0] d_Addr,
  input  logic [15:0] d_DataIn,
  input  logic        d_Rd,
  input  logic        d_Wr,
  output logic [15:0] d_DataOut,
  output logic        d_Done,
  output logic        d_Stall,
  output logic        d_err,
  output logic [15:0] m_Addr,
  output logic [15:0] m_DataIn,
  output logic        m_Rd,
  output logic        m_Wr,
  input  logic [15:0] m_DataOut,
  input  logic        m_Done,
  input  logic        m_err
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  localparam logic [7:0] LP_CNT_MAX = 8'(TIMEOUT - 1);

  state_t      r_state;
  owner_t      r_owner;
  owner_t      r_last;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_i_data;
  logic [15:0] r_d_data;
  logic        r_m_rd;
  logic        r_m_wr;
  logic        r_i_done;
  logic        r_d_done;

  logic w_i_req;
  logic w_d_req;
  logic w_d_bad;
  logic w_grant_i;

  // A data port asserting both read and write is not a legal requester.
  assign w_i_req   = i_Rd;
  assign w_d_req   = d_Rd ^ d_Wr;
  assign w_d_bad   = d_Rd & d_Wr;
  assign w_grant_i = w_i_req && (!w_d_req || (r_last == OWN_D));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_owner  <= OWN_I;
      r_last   <= OWN_I;
      r_cnt    <= 8'd0;
      r_err    <= 1'b0;
      r_addr   <= 16'd0;
      r_wdata  <= 16'd0;
      r_i_data <= 16'd0;
      r_d_data <= 16'd0;
      r_m_rd   <= 1'b0;
      r_m_wr   <= 1'b0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else begin
      r_m_rd   <= 1'b0;
      r_m_wr   <= 1'b0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_i) begin
            r_owner <= OWN_I;
            r_addr  <= i_Addr;
            r_m_rd  <= 1'b1;
            r_state <= S_ISSUE;
          end else if (w_d_req) begin
            r_owner <= OWN_D;
            r_addr  <= d_Addr;
            r_wdata <= d_DataIn;
            r_m_rd  <= d_Rd;
            r_m_wr  <= d_Wr;
            r_state <= S_ISSUE;
          end else if (w_d_bad) begin
            r_owner  <= OWN_D;
            r_err    <= 1'b1;
            r_d_done <= 1'b1;
            r_state  <= S_RESP;
          end
        end
        S_ISSUE: begin
          r_last  <= r_owner;
          r_cnt   <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (m_Done) begin
            if (r_owner == OWN_I) r_i_data <= m_DataOut;
            else                  r_d_data <= m_DataOut;
            r_err    <= m_err;
            r_i_done <= (r_owner == OWN_I);
            r_d_done <= (r_owner == OWN_D);
            r_state  <= S_RESP;
          end else if (m_err || (r_cnt == LP_CNT_MAX)) begin
            r_err    <= 1'b1;
            r_i_done <= (r_owner == OWN_I);
            r_d_done <= (r_owner == OWN_D);
            r_state  <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_Addr    = r_addr;
  assign m_DataIn  = r_wdata;
  assign m_Rd      = r_m_rd;
  assign m_Wr      = r_m_wr;
  assign i_Done    = r_i_done;
  assign d_Done    = r_d_done;
  assign i_err     = r_i_done & r_err;
  assign d_err     = r_d_done & r_err;
  assign i_DataOut = r_i_data;
  assign d_DataOut = r_d_data;

  assign i_Stall = i_Rd && !((r_state == S_RESP) && (r_owner == OWN_I));
  assign d_Stall = (d_Rd || d_Wr) && !((r_state == S_RESP) && (r_owner == OWN_D));
endmodule
